ascon_fsm: RTL and testbench

- Masked Ascon-p[12] permutation core with d Boolean shares per bit.
- Loads a 320-bit unmasked state, splits it into shares internally, and runs 12 rounds.
- The S-layer uses HPC2 masked AND gadgets, with 16 S-box columns processed per slice.
- Used as the permutation engine of the DPA-protected Ascon datapath; the result is delivered in masked form.

---
 rtl/ascon_fsm.sv | 272 +++++++++++++++++++++++++++
 tb/tb_ascon_fsm.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_fsm.sv
// Masked Ascon-p[12] permutation core.
// The unmasked 320-bit input is split into d Boolean shares (share 0 carries
// the value, the others start at zero). Twelve rounds are then run: the S-layer
// handles 16 columns per slice using HPC2 masked AND gadgets, and the linear
// layer is applied sharewise. The result stays in masked form on `out`.
//
// Control handshake: `start` is a single-cycle request. It is honoured only
// in IDLE or DONE, where it samples `in` and launches a run. It is ignored in
// every other state. `done` is a level that rises one edge after the final
// LINEAR cycle. It holds, together with `out`, until the next accepted start
// or a reset.
module ascon_fsm #(
  parameter  int d             = 2,
  localparam int and_pini_nrnd = d * (d - 1) / 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [16*5*and_pini_nrnd-1:0] rnd,
  input  logic [319:0]                  in,
  output logic                          done,
  output logic [320*d-1:0]              out,
  output logic [2:0]                    fsm_state
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] SBOX_ISSUE = 3'd1;
  localparam logic [2:0] SBOX_WB    = 3'd2;
  localparam logic [2:0] LINEAR     = 3'd3;
  localparam logic [2:0] DONE       = 3'd4;

  localparam int NR = and_pini_nrnd;

  // Rotation amounts of the linear layer, one pair per state word x0..x4.
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  // Control registers.
  logic [2:0] state_q;
  logic [3:0] round_q;
  logic [1:0] slice_q;
  logic       done_q;

  // Masked state. sh_q[r][j] holds the d shares of bit j of word x_r.
  logic [d-1:0] sh_q [5][64];

  // S-box pipeline registers, captured on the SBOX_ISSUE edge.
  // pre_q : the five words of each column after the affine input layer.
  // bm_q  : bm_q[c][a][i][j] = b_j ^ r_ij for j != i. The diagonal holds b_i.
  // r_q   : the gadget randomness, re-used in the second HPC2 stage.
  logic [d-1:0]  pre_q [16][5];
  logic [d-1:0]  bm_q  [16][5][d];
  logic [NR-1:0] r_q   [16][5];

  // Next-value nets.
  logic [d-1:0] pre_d [16][5];
  logic [d-1:0] bm_d  [16][5][d];
  logic [d-1:0] y_d   [16][5];
  logic [d-1:0] lin_d [5][64];
  logic [7:0]   rc;

  // Index of the shared random bit r_ij (= r_ji) inside one gadget's slot.
  function automatic int pidx(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * d - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  // 64-bit rotate right.
  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Round constant for the current round: 0xF0, 0xE1, ..., 0x4B.
  assign rc = 8'hF0 - ({4'd0, round_q} * 8'h0F);

  // Issue stage: gather the current slice, add the round constant on slice 0,
  // apply the sharewise input layer, and pre-mask the b operands of each AND.
  always_comb begin : issue_comb
    logic [d-1:0] xv [5];
    for (int c = 0; c < 16; c++) begin
      for (int r = 0; r < 5; r++) begin
        xv[r] = sh_q[r][{slice_q, c[3:0]}];
      end
      if (slice_q == 2'd0 && c < 8) begin
        xv[2][0] = xv[2][0] ^ rc[c[2:0]];
      end
      xv[0] = xv[0] ^ xv[4];
      xv[4] = xv[4] ^ xv[3];
      xv[2] = xv[2] ^ xv[1];
      for (int r = 0; r < 5; r++) begin
        pre_d[c][r] = xv[r];
      end
      for (int a = 0; a < 5; a++) begin
        for (int i = 0; i < d; i++) begin
          for (int j = 0; j < d; j++) begin
            if (j == i) begin
              bm_d[c][a][i][j] = xv[(a + 1) % 5][j];
            end else begin
              bm_d[c][a][i][j] = xv[(a + 1) % 5][j] ^ rnd[(c * 5 + a) * NR + pidx(i, j)];
            end
          end
        end
      end
    end
  end

  // Writeback stage: second HPC2 stage on registered operands, then the
  // chi-like combination and the affine output layer of the S-box.
  always_comb begin : sbox_wb_comb
    logic [d-1:0] av;
    logic [d-1:0] t [5];
    logic [d-1:0] y [5];
    for (int c = 0; c < 16; c++) begin
      for (int a = 0; a < 5; a++) begin
        av    = pre_q[c][a];
        av[0] = ~av[0];
        for (int i = 0; i < d; i++) begin
          t[a][i] = av[i] & bm_q[c][a][i][i];
          for (int j = 0; j < d; j++) begin
            if (j != i) begin
              t[a][i] = t[a][i] ^ (~av[i] & r_q[c][a][pidx(i, j)])
                                ^ (av[i] & bm_q[c][a][i][j]);
            end
          end
        end
      end
      for (int a = 0; a < 5; a++) begin
        y[a] = pre_q[c][a] ^ t[(a + 1) % 5];
      end
      y[1]    = y[1] ^ y[0];
      y[0]    = y[0] ^ y[4];
      y[3]    = y[3] ^ y[2];
      y[2][0] = ~y[2][0];
      for (int r = 0; r < 5; r++) begin
        y_d[c][r] = y[r];
      end
    end
  end

  // Linear diffusion layer, applied to each share independently.
  always_comb begin : linear_comb
    logic [63:0] w;
    logic [63:0] v;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < d; k++) begin
        for (int j = 0; j < 64; j++) begin
          w[j] = sh_q[r][j][k];
        end
        v = w ^ ror64(w, ROT_A[r]) ^ ror64(w, ROT_B[r]);
        for (int j = 0; j < 64; j++) begin
          lin_d[r][j][k] = v[j];
        end
      end
    end
  end

  // Control FSM: slice/round sequencing and the done flag.
  always_ff @(posedge clk or posedge reset) begin : ctrl_fsm
    if (reset) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      slice_q <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= SBOX_ISSUE;
            round_q <= 4'd0;
            slice_q <= 2'd0;
            done_q  <= 1'b0;
          end else if (state_q == DONE) begin
            done_q <= 1'b1;
          end
        end
        SBOX_ISSUE: state_q <= SBOX_WB;
        SBOX_WB: begin
          // Slice wraps to 0 after slice 3, ready for the next round.
          slice_q <= slice_q + 2'd1;
          state_q <= (slice_q == 2'd3) ? LINEAR : SBOX_ISSUE;
        end
        LINEAR: begin
          if (round_q == 4'd11) begin
            state_q <= DONE;
          end else begin
            round_q <= round_q + 4'd1;
            state_q <= SBOX_ISSUE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Masked state register: load, S-box writeback of one slice, linear layer.
  always_ff @(posedge clk or posedge reset) begin : state_regs
    if (reset) begin
      for (int r = 0; r < 5; r++) begin
        for (int j = 0; j < 64; j++) begin
          sh_q[r][j] <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            for (int r = 0; r < 5; r++) begin
              for (int j = 0; j < 64; j++) begin
                sh_q[r][j] <= {{(d-1){1'b0}}, in[(4 - r) * 64 + j]};
              end
            end
          end
        end
        SBOX_WB: begin
          for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 64; j++) begin
              if (j[5:4] == slice_q) begin
                sh_q[r][j] <= y_d[j[3:0]][r];
              end
            end
          end
        end
        LINEAR: begin
          for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 64; j++) begin
              sh_q[r][j] <= lin_d[r][j];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // First HPC2 stage: register the input-layer words, masked b operands and
  // randomness so that shares only meet again behind a register.
  always_ff @(posedge clk or posedge reset) begin : sbox_pipe
    if (reset) begin
      for (int c = 0; c < 16; c++) begin
        for (int a = 0; a < 5; a++) begin
          pre_q[c][a] <= '0;
          r_q[c][a]   <= '0;
          for (int i = 0; i < d; i++) begin
            bm_q[c][a][i] <= '0;
          end
        end
      end
    end else if (state_q == SBOX_ISSUE) begin
      for (int c = 0; c < 16; c++) begin
        for (int a = 0; a < 5; a++) begin
          pre_q[c][a] <= pre_d[c][a];
          r_q[c][a]   <= rnd[(c * 5 + a) * NR +: NR];
          for (int i = 0; i < d; i++) begin
            bm_q[c][a][i] <= bm_d[c][a][i];
          end
        end
      end
    end
  end

  // Output mapping: state bit i (x0 at the top) occupies out[d*i +: d].
  for (genvar gi = 0; gi < 320; gi++) begin : g_out
    assign out[d*gi +: d] = sh_q[4 - gi / 64][gi % 64];
  end

  assign done      = done_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_ascon_fsm.sv
// Testbench for ascon_fsm. An unmasked software Ascon-p[12] model provides
// the expected results. Table-driven runs are followed by hand-written
// sequences for reset, mid-run start and restart from DONE.
module tb_ascon_fsm;

  localparam int D    = 2;
  localparam int NRND = D * (D - 1) / 2;
  localparam int RW   = 16 * 5 * NRND;
  localparam int LAT  = 109;

  localparam logic [319:0] IV_IN = {64'h80400c0600000000, 64'h0001020304050607,
                                    64'h08090a0b0c0d0e0f, 64'h0001020304050607,
                                    64'h08090a0b0c0d0e0f};

  logic            clk;
  logic            reset;
  logic            start;
  logic [RW-1:0]   rnd;
  logic [319:0]    in_s;
  logic            done;
  logic [320*D-1:0] out;
  logic [2:0]      fsm_state;

  int   n_checks;
  int   n_errors;
  int   edge_cnt;
  bit   rnd_ones;
  logic [319:0] exp_q[$];

  ascon_fsm #(.d(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rnd       (rnd),
    .in        (in_s),
    .done      (done),
    .out       (out),
    .fsm_state (fsm_state)
  );

  // Clock and edge counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  // Fresh randomness every cycle, either all-ones or random.
  initial begin
    rnd = '1;
    forever begin
      @(negedge clk);
      if (rnd_ones) rnd = '1;
      else for (int i = 0; i < RW; i++) rnd[i] = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- golden model ----------------
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_p12(input logic [319:0] s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    for (int r = 0; r < 12; r++) begin
      x2 = x2 ^ 64'(240 - 15 * r);
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
      x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
      x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] unmask(input logic [320*D-1:0] o);
    logic [319:0] u;
    for (int i = 0; i < 320; i++) u[i] = ^o[D*i +: D];
    return u;
  endfunction

  // ---------------- checking and driver tasks ----------------
  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Pulses start for one cycle; returns the edge count of the sampling edge.
  task automatic pulse_start(input logic [319:0] v, output int t0);
    @(negedge clk);
    start = 1'b1;
    in_s  = v;
    @(negedge clk);
    start = 1'b0;
    in_s  = $urandom();
    t0    = edge_cnt;
  endtask

  // Waits (bounded) for done; returns the edge count where it was seen.
  task automatic wait_done(output int t1);
    int guard;
    guard = 0;
    while (!done && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    t1 = edge_cnt;
  endtask

  // Pops the expected result and compares the unmasked output.
  task automatic score(input string name);
    logic [319:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard queue empty", name);
    end else begin
      e = exp_q.pop_front();
      chk(name, 640'(unmask(out)), 640'(e));
    end
  endtask

  typedef struct {
    string        name;
    logic [319:0] in_v;
    bit           ones;
  } vec_t;

  vec_t vecs[5];
  logic [320*D-1:0] raw_ones;
  logic [320*D-1:0] raw_rand;
  logic [320*D-1:0] held;

  initial begin
    int t0, t1, tmid;

    vecs[0] = '{name: "iv_ones", in_v: IV_IN,   ones: 1'b1};
    vecs[1] = '{name: "iv_rand", in_v: IV_IN,   ones: 1'b0};
    vecs[2] = '{name: "zeros",   in_v: '0,      ones: 1'b0};
    vecs[3] = '{name: "ones",    in_v: '1,      ones: 1'b0};
    vecs[4] = '{name: "pattern",
                in_v: {64'hdeadbeefcafef00d, 64'h0123456789abcdef, 64'hfedcba9876543210,
                       64'h5555aaaa5555aaaa, 64'h8000000000000001},
                ones: 1'b1};

    n_checks = 0;
    n_errors = 0;
    rnd_ones = 1'b1;
    start    = 1'b0;
    in_s     = '0;
    raw_ones = '0;
    raw_rand = '0;

    // Reset held for 4 cycles.
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_done", 640'(done), 640'(0));
    chk("reset_out", 640'(out), 640'(0));
    chk("reset_fsm_idle", 640'(fsm_state), 640'(0));
    reset = 1'b0;

    // Table-driven runs.
    for (int v = 0; v < 5; v++) begin
      rnd_ones = vecs[v].ones;
      exp_q.push_back(ascon_p12(vecs[v].in_v));
      pulse_start(vecs[v].in_v, t0);
      wait_done(t1);
      chk({vecs[v].name, "_latency"}, 640'(t1 - t0), 640'(LAT));
      score({vecs[v].name, "_result"});
      held = out;
      if (v == 0) raw_ones = out;
      if (v == 1) raw_rand = out;
      repeat (3) @(negedge clk);
      chk({vecs[v].name, "_done_hold"}, 640'(done), 640'(1));
      chk({vecs[v].name, "_out_hold"}, 640'(out), 640'(held));
    end

    // Masks must actually differ between all-ones and random randomness.
    n_checks++;
    if (raw_ones == raw_rand) begin
      n_errors++;
      $display("FAIL shares_differ: got %h, expected a different share pattern", raw_rand);
    end

    // Reset pulsed 50 cycles into a run, then a fresh run.
    rnd_ones = 1'b0;
    pulse_start(IV_IN, t0);
    repeat (50) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_done", 640'(done), 640'(0));
    chk("midreset_out", 640'(out), 640'(0));
    chk("midreset_fsm_idle", 640'(fsm_state), 640'(0));
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(ascon_p12(IV_IN));
    pulse_start(IV_IN, t0);
    wait_done(t1);
    chk("after_reset_latency", 640'(t1 - t0), 640'(LAT));
    score("after_reset_result");

    // start re-asserted mid-run with a different input is ignored.
    exp_q.push_back(ascon_p12(vecs[4].in_v));
    pulse_start(vecs[4].in_v, t0);
    repeat (29) @(negedge clk);
    pulse_start('1, tmid);
    wait_done(t1);
    chk("midstart_latency", 640'(t1 - t0), 640'(LAT));
    score("midstart_result");

    // start from DONE clears done on the next edge and yields a second result.
    repeat (2) @(negedge clk);
    exp_q.push_back(ascon_p12(IV_IN));
    pulse_start(IV_IN, t0);
    chk("restart_done_clear", 640'(done), 640'(0));
    wait_done(t1);
    chk("restart_latency", 640'(t1 - t0), 640'(LAT));
    score("restart_result");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
